// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - stall/flush sequencer for the 5-stage pipeline
// Handles load-use stalls, mult/div EX freeze, taken-branch IF/ID flush and stall statistics.
module hazard_sequencer #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 5,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [4:0]        ex_rt,
  input  logic              id_branch_taken,
  input  logic              ex_md_start,
  input  logic              stall_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_bubble,
  output logic              exmem_bubble,
  output logic              md_busy,
  output logic              md_done,
  output logic [STAT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] md_cnt;
  logic             cnt_zero;
  logic             md_hold;
  logic             lu_hz;

  assign cnt_zero = (md_cnt == '0);
  assign md_busy  = (state == MD_BUSY);
  assign md_done  = (state == MD_BUSY) && cnt_zero;

  // Requests are masked during reset so a held ex_md_start cannot stall the quiet reset outputs.
  always_comb begin
    md_hold = !rst && (((state == RUN) && ex_md_start) || ((state == MD_BUSY) && !cnt_zero));
    lu_hz   = !rst && ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (md_hold) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else if (lu_hz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_branch_taken && !rst) begin
      ifid_flush = 1'b1;
    end
  end

  // Countdown starts at MD_LATENCY-2: the start cycle and the release cycle are both spent in EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_md_start) begin
            md_cnt <= CNT_W'(MD_LATENCY - 2);
            state  <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (!cnt_zero) begin
            md_cnt <= md_cnt - 1'b1;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state  <= RUN;
          md_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - self-checking bench for hazard_sequencer
// Vector table plus hand sequences for mult/div, reset abort and counter saturation.
module tb_hazard_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, id_branch_taken, ex_md_start, stall_clr;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble;
  logic        md_busy, md_done;
  logic [15:0] stall_cycles;

  hazard_sequencer #(.MD_LATENCY(4), .CNT_W(5), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
    .ex_md_start(ex_md_start), .stall_clr(stall_clr), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .md_busy(md_busy),
    .md_done(md_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // exp bits: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy, md_done}
  localparam logic [7:0] O_QUIET = 8'b1101_0000;
  localparam logic [7:0] O_LU    = 8'b0001_1000;
  localparam logic [7:0] O_BR    = 8'b1111_0000;
  localparam logic [7:0] O_MDRUN = 8'b0000_0100;
  localparam logic [7:0] O_MDB   = 8'b0000_0110;
  localparam logic [7:0] O_REL   = 8'b1101_0011;
  localparam logic [7:0] O_RELLU = 8'b0001_1011;

  typedef struct {
    logic       rst, md, mr, ur, br, clr;
    logic [4:0] rs, rt, ert;
    logic [7:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [7:0]  outs;
    logic [15:0] stall;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;

  function automatic vec_t mk(input string name, input logic r, input logic md, input logic mr,
                              input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                              input logic ur, input logic br, input logic clr, input logic [7:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.md = md; v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt;
    v.ur = ur; v.br = br; v.clr = clr; v.exp = exp;
    return v;
  endfunction

  // Called at a falling edge; drives, checks, then advances to the next falling edge.
  task automatic apply(input vec_t v);
    exp_t e;
    logic [7:0] got;
    rst = v.rst; ex_md_start = v.md; ex_memread = v.mr; ex_rt = v.ert;
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.ur; id_branch_taken = v.br; stall_clr = v.clr;
    if (v.rst) exp_stall = 0;
    sb.push_back('{outs: v.exp, stall: exp_stall[15:0]});
    #1;
    e = sb.pop_front();
    got = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, md_busy, md_done};
    checks++;
    if (got !== e.outs) begin
      errors++;
      $display("FAIL %s outputs: got %b expected %b", v.name, got, e.outs);
    end
    checks++;
    if (stall_cycles !== e.stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", v.name, stall_cycles, e.stall);
    end
    if (!v.rst) begin
      if (v.clr) exp_stall = 0;
      else if (!v.exp[7] && exp_stall < 65535) exp_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    tbl.push_back(mk("quiet",        0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));
    tbl.push_back(mk("lu_rs",        0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, O_LU));
    tbl.push_back(mk("lu_r0",        0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_QUIET));
    tbl.push_back(mk("rt_unused",    0, 0, 1, 5'd9, 5'd8, 5'd9, 0, 0, 0, O_QUIET));
    tbl.push_back(mk("lu_rt",        0, 0, 1, 5'd9, 5'd8, 5'd9, 1, 0, 0, O_LU));
    tbl.push_back(mk("no_load",      0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 0, 0, O_QUIET));
    tbl.push_back(mk("branch",       0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, O_BR));
    tbl.push_back(mk("lu_and_br",    0, 0, 1, 5'd31, 5'd31, 5'd2, 0, 1, 0, O_LU));
    tbl.push_back(mk("br_after_lu",  0, 0, 1, 5'd31, 5'd4, 5'd2, 0, 1, 0, O_BR));
    tbl.push_back(mk("br_r0_load",   0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, O_BR));

    rst = 1'b1; ex_md_start = 1'b1; ex_memread = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; id_branch_taken = 1'b0; stall_clr = 1'b0;
    @(negedge clk);

    // Reset with ex_md_start held, then MD_LATENCY=4 run entered straight out of reset
    apply(mk("rst_md_held", 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));
    apply(mk("md_start",    0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDRUN));
    apply(mk("md_busy1",    0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDB));
    apply(mk("md_busy2",    0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, O_MDB));
    apply(mk("md_release",  0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_REL));
    apply(mk("md_after",    0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // lu_hz in the release cycle is honoured
    apply(mk("md2_start",   0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDRUN));
    apply(mk("md2_busy1",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDB));
    apply(mk("md2_busy2",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDB));
    apply(mk("md2_rel_lu",  0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, O_RELLU));
    apply(mk("md2_lu_next", 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, O_LU));

    // Reset in the second MD_BUSY cycle aborts without md_done
    apply(mk("md3_start",   0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDRUN));
    apply(mk("md3_busy1",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_MDB));
    apply(mk("md3_rst",     1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));
    apply(mk("md3_post1",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));
    apply(mk("md3_post2",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));

    // Saturation of the stall counter, then clear
    apply(mk("pre_clr",     0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 1, O_LU));
    ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; stall_clr = 1'b0;
    repeat (65535) @(negedge clk);
    exp_stall = 65535;
    apply(mk("sat_reach",   0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, O_LU));
    apply(mk("sat_hold",    0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, O_LU));
    apply(mk("clr_pulse",   0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 1, O_LU));
    apply(mk("after_clr",   0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_QUIET));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
